unload_bram: RTL and testbench

Reads a contiguous block of 32-bit words out of the disparity-map BRAM through its read port and streams them, in address order, into an output FIFO (`px_out_fifo`). This is the read-side counterpart of `load_bram`, which fills the BRAM from `px_in_fifo`. A 4-entry internal skid buffer absorbs the BRAM read latency, so FIFO back-pressure never drops or duplicates a word.

---
 rtl/bram_disp_pkg.sv | 27 ++
 rtl/rd_skid_fifo.sv | 74 +++++++
 rtl/unload_bram.sv | 155 +++++++++++++++
 tb/tb_unload_bram.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_disp_pkg.sv
// ============================================================================
// bram_disp_pkg : shared types and constants for the disparity-map BRAM movers
// Config macro : UNLOAD_BRAM_OUTREG_EN (BRAM output register, read latency 2)
// Revision     : 1.0
// ============================================================================
`default_nettype none

package bram_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 4;

`ifdef UNLOAD_BRAM_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

endpackage

`default_nettype wire

// File: rtl/rd_skid_fifo.sv
// ============================================================================
// rd_skid_fifo : 4-entry first-word-fall-through buffer with occupancy count
// Revision     : 1.0
// ============================================================================
`default_nettype none

module rd_skid_fifo
  import bram_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic [2:0]  count,
  output logic        empty
);

  localparam int              PTR_W    = $clog2(SKID_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(SKID_DEPTH);

  logic [31:0]      mem_q [SKID_DEPTH];
  logic [31:0]      mem_d [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != FULL_CNT);
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: its contents are only visible when count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/unload_bram.sv
// ============================================================================
// unload_bram : streams a block of BRAM words into px_out_fifo in address order
// Config macro : UNLOAD_BRAM_OUTREG_EN (two-stage in-flight tracking)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module unload_bram
  import bram_disp_pkg::*;
#(
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  output logic             rd_clk_bram,
  output logic             en_bram,
  output logic [3:0]       we_bram,
  output logic [31:0]      addr_bram,
  input  logic [31:0]      dout_bram,
  output logic             wr_en_fifo,
  output logic [31:0]      dout_fifo,
  input  logic             full_fifo
);

  localparam logic [31:0] STEP       = 32'(ADDR_STEP);
  localparam logic [2:0]  SKID_LIMIT = 3'(SKID_DEPTH);

  state_t            state_q, state_d;
  logic [31:0]       cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [RD_LAT-1:0] inflight_q, inflight_d;
  logic              zero_done_q, zero_done_d;
  logic [2:0]        inflight_cnt;
  logic [2:0]        skid_count;
  logic [31:0]       skid_dout;
  logic              skid_empty, skid_push, skid_pop;
  logic              issue, last_issue, drained;

  assign rd_clk_bram  = clk;
  assign we_bram      = 4'b0000;
  assign addr_bram    = cur_addr_q;
  assign en_bram      = issue;
  assign skid_push    = inflight_q[RD_LAT-1];
  assign skid_pop     = !skid_empty && !full_fifo;
  assign wr_en_fifo   = skid_pop;
  assign dout_fifo    = skid_dout;
  assign inflight_cnt = 3'($countones(inflight_q));
  assign last_issue   = issue && ((issued_q + CNT_W'(1)) == num_q);
  // Finishing on the cycle of the final pop makes done land right after the last write.
  assign drained      = (inflight_cnt == 3'd0) &&
                        ((skid_count == 3'd0) || ((skid_count == 3'd1) && skid_pop));

  generate
    if (RD_LAT > 1) begin : g_lat_multi
      assign inflight_d = {inflight_q[RD_LAT-2:0], issue};
    end else begin : g_lat_single
      assign inflight_d = issue;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && (num_words != '0)) state_d = ST_RUN;
      ST_RUN:   if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (drained) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A read is issued only if the skid has a slot reserved for its returning data.
  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE:  done = zero_done_q;
      ST_RUN: begin
        busy  = 1'b1;
        issue = (issued_q < num_q) && ((skid_count + inflight_cnt) < SKID_LIMIT);
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cur_addr_d  = cur_addr_q;
    num_d       = num_q;
    issued_d    = issued_q;
    zero_done_d = 1'b0;
    if ((state_q == ST_IDLE) && start) begin
      if (num_words != '0) begin
        cur_addr_d = base_addr;
        num_d      = num_words;
        issued_d   = '0;
      end else begin
        zero_done_d = 1'b1;
      end
    end else if (issue) begin
      cur_addr_d = cur_addr_q + STEP;
      issued_d   = issued_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr_q  <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= '0;
      zero_done_q <= 1'b0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      zero_done_q <= zero_done_d;
    end
  end

  rd_skid_fifo u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (skid_push),
    .din   (dout_bram),
    .pop   (skid_pop),
    .dout  (skid_dout),
    .count (skid_count),
    .empty (skid_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_unload_bram.sv
// ============================================================================
// tb_unload_bram : directed, table-driven bench for unload_bram
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_unload_bram;
  import bram_disp_pkg::*;

  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] num_words;
  logic             busy, done, rd_clk_bram, en_bram, wr_en_fifo, full_fifo;
  logic [3:0]       we_bram;
  logic [31:0]      addr_bram, dout_bram, dout_fifo;

  unload_bram #(.ADDR_STEP(4), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .busy        (busy),
    .done        (done),
    .rd_clk_bram (rd_clk_bram),
    .en_bram     (en_bram),
    .we_bram     (we_bram),
    .addr_bram   (addr_bram),
    .dout_bram   (dout_bram),
    .wr_en_fifo  (wr_en_fifo),
    .dout_fifo   (dout_fifo),
    .full_fifo   (full_fifo)
  );

  always #5 clk = ~clk;

  // BRAM model preloaded with addr/4; optional output register stage.
  logic [31:0] bram_s1 = '0;
  logic [31:0] bram_s2 = '0;
  always @(posedge clk) begin
    if (en_bram) bram_s1 <= addr_bram >> 2;
    bram_s2 <= bram_s1;
  end
  assign dout_bram = (RD_LAT == 1) ? bram_s1 : bram_s2;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] base;
    int          num;
    int          f_lo;
    int          f_hi;
    int          e_first_en;
    int          e_first_wr;
    int          e_nwr;
    int          e_last_wr;
    int          e_done;
    bit          e_busy;
  } vec_t;

  vec_t vecs[4];

  int r_first_en, r_first_wr, r_last_wr, r_done, r_nwr, r_nen, r_ndone;
  int r_derr, r_aerr, r_rerr, r_ferr;
  bit r_busy;

  // One transfer started in cycle 0; optional second start at cycle restart_c.
  task automatic run_xfer(input logic [31:0] base, input int num, input int f_lo,
                          input int f_hi, input int restart_c);
    int c;
    logic [31:0] exp_d;
    r_first_en = -1; r_first_wr = -1; r_last_wr = -1; r_done = -1;
    r_nwr = 0; r_nen = 0; r_ndone = 0; r_busy = 0;
    r_derr = 0; r_aerr = 0; r_rerr = 0; r_ferr = 0;
    c = 0;
    while (c < 300 && !(r_ndone > 0 && c > r_done + 3)) begin
      @(posedge clk); #1;
      start     = (c == 0) || (c == restart_c);
      base_addr = (c == 0) ? base : base + 32'h100;
      num_words = (c == 0) ? CNT_W'(num) : CNT_W'(4);
      full_fifo = (c >= f_lo) && (c <= f_hi);
      #1;
      if (en_bram) begin
        if (r_first_en < 0) r_first_en = c;
        if (addr_bram !== base + 32'(r_nen * 4)) r_aerr++;
        if (r_nen - r_nwr >= SKID_DEPTH) r_rerr++;
        r_nen++;
      end
      if (wr_en_fifo) begin
        exp_d = (base + 32'(r_nwr * 4)) >> 2;
        if (dout_fifo !== exp_d) r_derr++;
        if (full_fifo) r_ferr++;
        if (r_first_wr < 0) r_first_wr = c;
        r_last_wr = c;
        r_nwr++;
      end
      if (done) begin
        r_ndone++;
        r_done = c;
      end
      if (busy) r_busy = 1;
      c++;
    end
    start     = 1'b0;
    full_fifo = 1'b0;
  endtask

  initial begin
    int nw;
    int stray;
    vecs[0] = '{32'h0000_0000, 16, -1, -1, 1, 2 + RD_LAT, 16, 17 + RD_LAT, 18 + RD_LAT, 1'b1};
    vecs[1] = '{32'h0000_0000, 16, 4, 10, 1, (RD_LAT == 1) ? 3 : 11, 16, 24 + RD_LAT,
                25 + RD_LAT, 1'b1};
    vecs[2] = '{32'hFFFF_FFF8, 4, -1, -1, 1, 2 + RD_LAT, 4, 5 + RD_LAT, 6 + RD_LAT, 1'b1};
    vecs[3] = '{32'h0000_0000, 0, -1, -1, -1, -1, 0, -1, 1, 1'b0};

    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; full_fifo = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en_bram", en_bram, 0);
    chk("rst_addr_bram", addr_bram, 0);
    chk("rst_wr_en_fifo", wr_en_fifo, 0);
    chk("we_bram", we_bram, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_xfer(vecs[i].base, vecs[i].num, vecs[i].f_lo, vecs[i].f_hi, -1);
      chk($sformatf("v%0d_first_en", i), r_first_en, vecs[i].e_first_en);
      chk($sformatf("v%0d_first_wr", i), r_first_wr, vecs[i].e_first_wr);
      chk($sformatf("v%0d_n_wr", i), r_nwr, vecs[i].e_nwr);
      chk($sformatf("v%0d_n_en", i), r_nen, vecs[i].num);
      chk($sformatf("v%0d_last_wr", i), r_last_wr, vecs[i].e_last_wr);
      chk($sformatf("v%0d_done_cyc", i), r_done, vecs[i].e_done);
      chk($sformatf("v%0d_n_done", i), r_ndone, 1);
      chk($sformatf("v%0d_busy_seen", i), r_busy, vecs[i].e_busy);
      chk($sformatf("v%0d_data_err", i), r_derr, 0);
      chk($sformatf("v%0d_addr_err", i), r_aerr, 0);
      chk($sformatf("v%0d_resv_err", i), r_rerr, 0);
      chk($sformatf("v%0d_wr_while_full", i), r_ferr, 0);
    end

    // Second start while busy must be ignored.
    run_xfer(32'h0, 8, -1, -1, 3);
    chk("restart_n_done", r_ndone, 1);
    chk("restart_n_wr", r_nwr, 8);
    chk("restart_n_en", r_nen, 8);
    chk("restart_data_err", r_derr, 0);
    chk("restart_done_cyc", r_done, 10 + RD_LAT);

    // Reset in the middle of a 16-word transfer after 5 words.
    nw = 0;
    for (int k = 0; k < 60 && nw < 5; k++) begin
      @(posedge clk); #1;
      start     = (k == 0);
      base_addr = 32'h0;
      num_words = CNT_W'(16);
      #1;
      if (wr_en_fifo) nw++;
    end
    start = 1'b0;
    chk("mid_words_before_rst", nw, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_en_bram", en_bram, 0);
    chk("mid_rst_addr_bram", addr_bram, 0);
    chk("mid_rst_wr_en_fifo", wr_en_fifo, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
      if (wr_en_fifo || en_bram || busy || done) stray++;
    end
    chk("post_rst_stray", stray, 0);

    run_xfer(32'h0, 8, -1, -1, -1);
    chk("post_rst_n_wr", r_nwr, 8);
    chk("post_rst_data_err", r_derr, 0);
    chk("post_rst_n_done", r_ndone, 1);
    chk("post_rst_done_cyc", r_done, 10 + RD_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
